// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Configuration sequencer for the PWM block. Owns the ARR/CCR/dir settings
// seen by the PWM and only changes them on the edge that ends a PWM period.
// This keeps every period whole. A configuration request soft-ramps CCR
// toward a target in fixed steps, taking one step every (hold+1) periods.
//
// Optional build macro: PWM_RAMP_SAFE_ABORT_EN
//   defined   - abort parks the block in SAFE, forces CCR to 0 at the next
//               period boundary, then returns to IDLE without a done pulse.
//   undefined - abort freezes the PWM settings and returns to IDLE at once.

module pwm_ramp_ctrl #(
   parameter int WIDTH   = 16,
   parameter int HOLD_W  = 8,
   parameter int ARR_RST = 999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_arr,
   input  logic [WIDTH-1:0]  cfg_ccr,
   input  logic              cfg_dir,
   input  logic [WIDTH-1:0]  cfg_step,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic              abort,
   output logic [WIDTH-1:0]  pwm_arr,
   output logic [WIDTH-1:0]  pwm_ccr,
   output logic              pwm_dir,
   output logic              period_tick,
   output logic              busy,
   output logic              done
);

   localparam logic [WIDTH-1:0] ArrRstVal = WIDTH'(ARR_RST);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      RAMP = 3'd2,
      DONE = 3'd3,
      SAFE = 3'd4
   } state_t;

`ifdef PWM_RAMP_SAFE_ABORT_EN
   localparam state_t AbortState = SAFE;
`else
   localparam state_t AbortState = IDLE;
`endif

   state_t            state_q;
   logic [WIDTH-1:0]  pcnt_q;
   logic [WIDTH-1:0]  arr_q;
   logic [WIDTH-1:0]  ccr_q;
   logic              dir_q;
   logic [HOLD_W-1:0] holdCnt_q;

   logic [WIDTH-1:0]  latArr_q;
   logic [WIDTH-1:0]  latTgt_q;
   logic [WIDTH-1:0]  latStep_q;
   logic [HOLD_W-1:0] latHold_q;
   logic              latDir_q;

   logic              tick;
   logic [WIDTH-1:0]  cfgTgt_d;
   logic [WIDTH-1:0]  armCcr_d;
   logic [WIDTH-1:0]  stepCcr_d;
   logic [WIDTH:0]    upGap;
   logic [WIDTH:0]    dnGap;
   logic [WIDTH:0]    stepWide;

   // The last cycle of a period is the one where the counter sits on ARR.
   assign tick = (pcnt_q == arr_q);

   // Clamped target, the CCR allowed under the new ARR, and the next ramp
   // value. Gaps are taken one bit wider so a subtraction can never wrap.
   always_comb begin
      cfgTgt_d  = (cfg_ccr < cfg_arr) ? cfg_ccr : cfg_arr;
      armCcr_d  = (ccr_q < latArr_q) ? ccr_q : latArr_q;
      upGap     = {1'b0, latTgt_q} - {1'b0, ccr_q};
      dnGap     = {1'b0, ccr_q} - {1'b0, latTgt_q};
      stepWide  = {1'b0, latStep_q};
      stepCcr_d = latTgt_q;
      if (latTgt_q > ccr_q) begin
         if (upGap > stepWide) begin
            stepCcr_d = ccr_q + latStep_q;
         end
      end else if (latTgt_q < ccr_q) begin
         if (dnGap > stepWide) begin
            stepCcr_d = ccr_q - latStep_q;
         end
      end
   end

   // Free-running period counter; wraps on the same edge that may load a new ARR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q <= '0;
      end else if (tick) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + WIDTH'(1);
      end
   end

   // Sequencer: accept a request, apply ARR/dir at a boundary, then ramp CCR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         arr_q     <= ArrRstVal;
         ccr_q     <= '0;
         dir_q     <= 1'b1;
         holdCnt_q <= '0;
         latArr_q  <= ArrRstVal;
         latTgt_q  <= '0;
         latStep_q <= '0;
         latHold_q <= '0;
         latDir_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  latArr_q  <= cfg_arr;
                  latTgt_q  <= cfgTgt_d;
                  latStep_q <= cfg_step;
                  latHold_q <= cfg_hold;
                  latDir_q  <= cfg_dir;
                  state_q   <= ARM;
               end
            end
            ARM: begin
               if (abort) begin
                  state_q <= AbortState;
               end else if (tick) begin
                  arr_q     <= latArr_q;
                  dir_q     <= latDir_q;
                  holdCnt_q <= '0;
                  if (latStep_q == '0) begin
                     ccr_q   <= latTgt_q;
                     state_q <= DONE;
                  end else begin
                     ccr_q   <= armCcr_d;
                     state_q <= RAMP;
                  end
               end
            end
            RAMP: begin
               if (abort) begin
                  state_q <= AbortState;
               end else if (tick) begin
                  if (ccr_q == latTgt_q) begin
                     state_q <= DONE;
                  end else if (holdCnt_q == latHold_q) begin
                     holdCnt_q <= '0;
                     ccr_q     <= stepCcr_d;
                     if (stepCcr_d == latTgt_q) begin
                        state_q <= DONE;
                     end
                  end else begin
                     holdCnt_q <= holdCnt_q + HOLD_W'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
`ifdef PWM_RAMP_SAFE_ABORT_EN
            SAFE: begin
               if (tick) begin
                  ccr_q   <= '0;
                  state_q <= IDLE;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pwm_arr   = arr_q;
   assign pwm_ccr   = ccr_q;
   assign pwm_dir   = dir_q;
   assign period_tick = tick;
   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q == ARM) || (state_q == RAMP) || (state_q == SAFE);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
// Self-checking bench for pwm_ramp_ctrl. A transaction-level model turns each
// accepted request into a queue of settings to apply at successive period
// boundaries. Honors PWM_RAMP_SAFE_ABORT_EN the same way as the design.

module tb_pwm_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfgValid = 1'b0;
   logic [15:0] cfgArr = '0;
   logic [15:0] cfgCcr = '0;
   logic        cfgDir = 1'b0;
   logic [15:0] cfgStep = '0;
   logic [7:0]  cfgHold = '0;
   logic        abortIn = 1'b0;
   logic        cfgReady;
   logic [15:0] pwmArr;
   logic [15:0] pwmCcr;
   logic        pwmDir;
   logic        periodTick;
   logic        busyO;
   logic        doneO;

   int vectors = 0;
   int miscompares = 0;

   pwm_ramp_ctrl #(.WIDTH(16), .HOLD_W(8), .ARR_RST(999)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfgValid), .cfg_ready(cfgReady),
      .cfg_arr(cfgArr), .cfg_ccr(cfgCcr), .cfg_dir(cfgDir),
      .cfg_step(cfgStep), .cfg_hold(cfgHold), .abort(abortIn),
      .pwm_arr(pwmArr), .pwm_ccr(pwmCcr), .pwm_dir(pwmDir),
      .period_tick(periodTick), .busy(busyO), .done(doneO)
   );

   always #5 clk = ~clk;

   wire logic [36:0] obsVec = {pwmArr, pwmCcr, pwmDir, periodTick, busyO, doneO, cfgReady};
   localparam logic [36:0] ResetVec = {16'd999, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   // Reference model: settings as the PWM sees them, plus the plan of updates
   // still to be applied, one entry per period boundary.
   typedef struct {int arr; int dir; int ccr; bit last;} upd_t;
   upd_t plan[$];
   int mPcnt, mArr, mCcr, mDir;
   int mPhase;   // 0 idle, 1 sequencing, 2 done pulse, 3 safe wait
   bit mInArm;

   function automatic void resetModel();
      mPcnt = 0; mArr = 999; mCcr = 0; mDir = 1; mPhase = 0; mInArm = 0;
      plan.delete();
   endfunction

   function automatic void buildPlan(int arr, int ccr, int dir, int step, int hold);
      int tgt;
      int c;
      tgt = (ccr < arr) ? ccr : arr;
      c = (mCcr < arr) ? mCcr : arr;
      plan.delete();
      if (step == 0) begin
         plan.push_back('{arr, dir, tgt, 1'b1});
      end else begin
         plan.push_back('{arr, dir, c, 1'b0});
         if (c == tgt) begin
            plan.push_back('{arr, dir, c, 1'b1});
         end else begin
            while (c != tgt) begin
               for (int h = 0; h < hold; h++) plan.push_back('{arr, dir, c, 1'b0});
               if (tgt > c) c = (tgt - c <= step) ? tgt : c + step;
               else         c = (c - tgt <= step) ? tgt : c - step;
               plan.push_back('{arr, dir, c, (c == tgt)});
            end
         end
      end
   endfunction

   function automatic void modelStep();
      bit tk;
      upd_t u;
      tk = (mPcnt == mArr);
      mPcnt = tk ? 0 : mPcnt + 1;
      case (mPhase)
         0: if (cfgValid) begin
               buildPlan(int'(cfgArr), int'(cfgCcr), int'(cfgDir), int'(cfgStep), int'(cfgHold));
               mPhase = 1; mInArm = 1;
            end
         1: if (abortIn) begin
               plan.delete();
               mInArm = 0;
`ifdef PWM_RAMP_SAFE_ABORT_EN
               mPhase = 3;
`else
               mPhase = 0;
`endif
            end else if (tk) begin
               u = plan.pop_front();
               mArr = u.arr; mDir = u.dir; mCcr = u.ccr; mInArm = 0;
               if (u.last) mPhase = 2;
            end
         2: mPhase = 0;
         default: if (tk) begin mCcr = 0; mPhase = 0; end
      endcase
   endfunction

   function automatic logic [36:0] expVec();
      logic b;
      b = (mPhase == 1) || (mPhase == 3);
      return {mArr[15:0], mCcr[15:0], mDir[0], (mPcnt == mArr), b, (mPhase == 2), (mPhase == 0)};
   endfunction

   // Model advances on the same edges as the design.
   initial begin
      resetModel();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) resetModel();
         else modelStep();
      end
   end

   task automatic applyStimulus(input int arr, input int ccr, input int dir,
                                input int step, input int hold);
      cfgArr = 16'(arr); cfgCcr = 16'(ccr); cfgDir = dir[0];
      cfgStep = 16'(step); cfgHold = 8'(hold);
      cfgValid = 1'b1;
      @(negedge clk);
      cfgValid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (obsVec !== ResetVec) begin
         miscompares++;
         $display("[TB] FAIL reset_state got %h exp %h", obsVec, ResetVec);
      end
      rst = 1'b1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec() || periodTick !== (k % 1000 == 999)) begin
            miscompares++;
            $display("[TB] FAIL reset_period k=%0d got %h exp %h", k, obsVec, expVec());
         end
      end
   endtask

   task automatic test_ramp_up();
      int seen[$];
      int expSeq[5] = '{100, 200, 300, 400, 499};
      int prev = 0;
      int doneCnt = 0;
      applyStimulus(999, 499, 1, 100, 0);
      for (int n = 0; n < 8000; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL ramp_up t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (int'(pwmCcr) != prev) begin seen.push_back(int'(pwmCcr)); prev = int'(pwmCcr); end
         if (doneO === 1'b1) doneCnt++;
         if (mPhase == 0) break;
      end
      vectors++;
      if (seen.size() != 5 || doneCnt != 1 || cfgReady !== 1'b1 || mPhase != 0) begin
         miscompares++;
         $display("[TB] FAIL ramp_up_seq got %0d changes done=%0d ready=%b exp 5 changes done=1 ready=1",
                  seen.size(), doneCnt, cfgReady);
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (seen[i] != expSeq[i]) begin
               miscompares++;
               $display("[TB] FAIL ramp_up_val[%0d] got %0d exp %0d", i, seen[i], expSeq[i]);
            end
         end
      end
   endtask

   task automatic test_ramp_down();
      int seen[$];
      int when[$];
      int expSeq[3] = '{349, 199, 99};
      int prev = 499;
      applyStimulus(999, 99, 0, 150, 1);
      for (int n = 0; n < 9000; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL ramp_down t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (int'(pwmCcr) != prev) begin
            seen.push_back(int'(pwmCcr)); when.push_back(n); prev = int'(pwmCcr);
         end
         if (mPhase == 0) break;
      end
      vectors++;
      if (seen.size() != 3 || mPhase != 0 || pwmDir !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ramp_down_seq got %0d changes dir=%b exp 3 changes dir=0", seen.size(), pwmDir);
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (seen[i] != expSeq[i] || (i > 0 && when[i] - when[i-1] != 2000)) begin
               miscompares++;
               $display("[TB] FAIL ramp_down_val[%0d] got %0d exp %0d", i, seen[i], expSeq[i]);
            end
         end
      end
   endtask

   task automatic test_jump_clamp();
      int ticks[$];
      int doneCnt = 0;
      applyStimulus(199, 999, 1, 0, 0);
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL jump t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (periodTick === 1'b1) ticks.push_back(n);
         if (doneO === 1'b1) doneCnt++;
      end
      vectors++;
      if (pwmArr !== 16'd199 || pwmCcr !== 16'd199 || doneCnt != 1) begin
         miscompares++;
         $display("[TB] FAIL jump_clamp got arr=%0d ccr=%0d done=%0d exp 199 199 1", pwmArr, pwmCcr, doneCnt);
      end
      vectors++;
      if (ticks.size() < 3 || ticks[1] - ticks[0] != 200 || ticks[2] - ticks[1] != 200) begin
         miscompares++;
         $display("[TB] FAIL jump_period got %0d ticks exp gaps of 200", ticks.size());
      end
   endtask

   task automatic test_abort_ramp();
      int doneCnt = 0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(999, 499, 1, 100, 0);
      for (int n = 0; n < 6000; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL abort_ramp t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (mCcr == 300) break;
         cfgValid = (n == 5); cfgCcr = 16'd7; cfgStep = 16'd0; cfgArr = 16'd50;
      end
      cfgValid = 1'b0;
      abortIn = 1'b1;
      @(negedge clk);
      abortIn = 1'b0;
      vectors++;
`ifdef PWM_RAMP_SAFE_ABORT_EN
      if ({busyO, cfgReady, pwmCcr} !== {1'b1, 1'b0, 16'd300}) begin
`else
      if ({busyO, cfgReady, pwmCcr} !== {1'b0, 1'b1, 16'd300}) begin
`endif
         miscompares++;
         $display("[TB] FAIL abort_ramp_now got busy=%b ready=%b ccr=%0d", busyO, cfgReady, pwmCcr);
      end
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL abort_ramp_after t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (doneO === 1'b1) doneCnt++;
      end
      vectors++;
`ifdef PWM_RAMP_SAFE_ABORT_EN
      if (pwmCcr !== 16'd0 || doneCnt != 0 || cfgReady !== 1'b1) begin
`else
      if (pwmCcr !== 16'd300 || doneCnt != 0 || cfgReady !== 1'b1) begin
`endif
         miscompares++;
         $display("[TB] FAIL abort_ramp_final got ccr=%0d done=%0d ready=%b", pwmCcr, doneCnt, cfgReady);
      end
   endtask

   task automatic test_abort_arm_tick();
      bit hit = 0;
      applyStimulus(199, 50, 1, 10, 0);
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL abort_arm t=%0t got %h exp %h", $time, obsVec, expVec());
         end
         if (mInArm && mPcnt == mArr) begin abortIn = 1'b1; hit = 1; break; end
      end
      vectors++;
      if (!hit || periodTick !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_arm_timeout got tick=%b exp 1", periodTick);
      end
      @(negedge clk);
      abortIn = 1'b0;
      vectors++;
      if (pwmArr !== 16'd999 || pwmDir !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_arm_arr got %0d exp 999", pwmArr);
      end
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec() || doneO !== 1'b0 || pwmArr !== 16'd999) begin
            miscompares++;
            $display("[TB] FAIL abort_arm_after t=%0t got %h exp %h", $time, obsVec, expVec());
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++) begin
         int abortAt;
         bit idle = 0;
         abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : -1;
         applyStimulus($urandom_range(3, 30), $urandom_range(0, 40), $urandom_range(0, 1),
                       ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12), $urandom_range(0, 2));
         for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            vectors++;
            if (obsVec !== expVec()) begin
               miscompares++;
               $display("[TB] FAIL random txn=%0d t=%0t got %h exp %h", t, $time, obsVec, expVec());
            end
            if (mPhase == 0) begin idle = 1; break; end
            abortIn = (n == abortAt);
            cfgValid = ($urandom_range(0, 15) == 0);
            cfgCcr = 16'($urandom_range(0, 60));
         end
         cfgValid = 1'b0;
         abortIn = 1'b0;
         if (!idle) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL random_timeout txn=%0d", t);
         end
      end
   endtask

   task automatic test_reset_midseq();
      applyStimulus(20, 15, 1, 1, 0);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL midseq t=%0t got %h exp %h", $time, obsVec, expVec());
         end
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (obsVec !== ResetVec) begin
         miscompares++;
         $display("[TB] FAIL midseq_reset got %h exp %h", obsVec, ResetVec);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         vectors++;
         if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL midseq_after t=%0t got %h exp %h", $time, obsVec, expVec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_jump_clamp();
      test_abort_ramp();
      test_abort_arm_tick();
      test_random();
      test_reset_midseq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
